// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand select, write-back forwarding and a 2-entry skid buffer ahead of the ALU.
// Define ALU_ISSUE_FWD_EN to forward write-back data into captured and held operands.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_rs_a,
  input  logic [4:0]  in_rs_b,
  input  logic [31:0] in_rdata_a,
  input  logic [31:0] in_rdata_b,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  ALUOp,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [4:0]  out_rd
);
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        rd;
    logic [4:0]        rs_a;
    logic [4:0]        rs_b;
    logic              b_imm;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;
  entry_t e0_q, e0_d, e1_q, e1_d;
  entry_t cap_raw, cap, e0_ref, e1_ref;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  always_comb begin
    cap_raw       = '0;
    cap_raw.op    = in_op;
    cap_raw.a     = in_rdata_a;
    cap_raw.b     = in_use_imm ? in_imm : in_rdata_b;
    cap_raw.rd    = in_rd;
    cap_raw.rs_a  = in_rs_a;
    cap_raw.rs_b  = in_rs_b;
    cap_raw.b_imm = in_use_imm;
  end

`ifdef ALU_ISSUE_FWD_EN
  // Same match rule serves both the incoming op and the held entries; r0 never forwards.
  function automatic entry_t refresh(input entry_t e, input logic wv,
                                     input logic [4:0] wrd, input logic [DATA_W-1:0] wd);
    entry_t r;
    r = e;
    if (wv && (wrd != 5'd0)) begin
      if (wrd == e.rs_a) r.a = wd;
      if (!e.b_imm && (wrd == e.rs_b)) r.b = wd;
    end
    return r;
  endfunction

  assign cap    = refresh(cap_raw, wb_valid, wb_rd, wb_data);
  assign e0_ref = refresh(e0_q, wb_valid, wb_rd, wb_data);
  assign e1_ref = refresh(e1_q, wb_valid, wb_rd, wb_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{wb_valid, wb_rd, wb_data};
  assign cap    = cap_raw;
  assign e0_ref = e0_q;
  assign e1_ref = e1_q;
`endif

  always_comb begin
    accept  = in_valid && in_ready_q;
    drain   = out_valid_q && out_ready;
    state_d = state_q;
    e0_d    = e0_ref;
    e1_d    = e1_ref;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          e0_d    = cap;
          state_d = ONE;
        end
        ONE: begin
          if (accept && drain) begin
            e0_d = cap;
          end else if (accept) begin
            e1_d    = cap;
            state_d = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: if (drain) begin
          e0_d    = e1_ref;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      e0_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      e0_q        <= e0_d;
    end
  end

  // Skid entry is only meaningful while FULL, so its payload needs no reset.
  always_ff @(posedge clk) begin
    e1_q <= e1_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUOp     = e0_q.op;
  assign SrcA      = e0_q.a;
  assign SrcB      = e0_q.b;
  assign out_rd    = e0_q.rd;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand sequences and random traffic vs. a queue model.
module tb_alu_issue_stage;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rs_a, in_rs_b, in_rd;
  logic [31:0] in_rdata_a, in_rdata_b, in_imm;
  logic        in_use_imm;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [1:0]  ALUOp;
  logic [31:0] SrcA, SrcB;
  logic [4:0]  out_rd;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
    .in_rdata_a(in_rdata_a), .in_rdata_b(in_rdata_b),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUOp(ALUOp), .SrcA(SrcA), .SrcB(SrcB), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd, rs_a, rs_b;
    logic        b_imm;
  } mop_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rs_a, rs_b, rd;
    logic [31:0] rda, rdb, imm;
    logic        use_imm, wbv;
    logic [4:0]  wb_rd;
    logic [31:0] wbd, exp_a, exp_b;
  } vec_t;

  mop_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [31:0] v, input logic [4:0] rs, input logic ok);
    if (FWD && ok && wb_valid && (wb_rd != 5'd0) && (wb_rd == rs)) return wb_data;
    return v;
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("ALUOp", ALUOp, q[0].op);
      chk("SrcA", SrcA, q[0].a);
      chk("SrcB", SrcB, q[0].b);
      chk("out_rd", out_rd, q[0].rd);
    end
  endtask

  // Model of one clock edge: FIFO of at most two ops.
  task automatic model_edge();
    logic acc, drn;
    mop_t n;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() != 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      foreach (q[i]) begin
        q[i].a = fwd(q[i].a, q[i].rs_a, 1'b1);
        q[i].b = fwd(q[i].b, q[i].rs_b, !q[i].b_imm);
      end
      if (acc) begin
        n.op    = in_op;
        n.rd    = in_rd;
        n.rs_a  = in_rs_a;
        n.rs_b  = in_rs_b;
        n.b_imm = in_use_imm;
        n.a     = fwd(in_rdata_a, in_rs_a, 1'b1);
        n.b     = in_use_imm ? in_imm : fwd(in_rdata_b, in_rs_b, 1'b1);
        q.push_back(n);
      end
    end
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] op, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] da, input logic [31:0] db, input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_rs_a = ra; in_rs_b = rb;
    in_rdata_a = da; in_rdata_b = db; in_imm = 32'd0; in_use_imm = 1'b0; in_rd = rd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_ALUOp"}, ALUOp, 2'b00);
    chk({tag, "_SrcA"}, SrcA, 32'd0);
    chk({tag, "_SrcB"}, SrcB, 32'd0);
    chk({tag, "_out_rd"}, out_rd, 5'd0);
  endtask

  vec_t        tbl[6];
  logic [31:0] got[$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_op(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    in_valid = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{2'b00, 5'd1, 5'd2, 5'd9,  32'd5,     32'd7,    32'd0,         1'b0, 1'b0, 5'd0, 32'd0,     32'd5,     32'd7};
    tbl[1] = '{2'b01, 5'd1, 5'd2, 5'd10, 32'd8,     32'd3,    32'hFFFFFFFF,  1'b1, 1'b0, 5'd0, 32'd0,     32'd8,     32'hFFFFFFFF};
    tbl[2] = '{2'b00, 5'd3, 5'd2, 5'd3,  32'd1,     32'd2,    32'd0,         1'b0, 1'b1, 5'd3, 32'h55,    FWD ? 32'h55 : 32'd1, 32'd2};
    tbl[3] = '{2'b10, 5'd0, 5'd2, 5'd4,  32'd1,     32'hF0,   32'd0,         1'b0, 1'b1, 5'd0, 32'h55,    32'd1,     32'hF0};
    tbl[4] = '{2'b11, 5'd5, 5'd4, 5'd31, 32'hDEAD,  32'h77,   32'h1234,      1'b1, 1'b1, 5'd4, 32'h99,    32'hDEAD,  32'h1234};
    tbl[5] = '{2'b01, 5'd7, 5'd6, 5'd6,  32'h11,    32'h22,   32'd0,         1'b0, 1'b1, 5'd6, 32'hA5A5,  32'h11,    FWD ? 32'hA5A5 : 32'h22};

    for (int i = 0; i < 6; i++) begin
      set_op(tbl[i].op, tbl[i].rs_a, tbl[i].rs_b, tbl[i].rda, tbl[i].rdb, tbl[i].rd);
      in_imm = tbl[i].imm; in_use_imm = tbl[i].use_imm;
      wb_valid = tbl[i].wbv; wb_rd = tbl[i].wb_rd; wb_data = tbl[i].wbd;
      cycle();
      in_valid = 1'b0; wb_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_ALUOp", i), ALUOp, tbl[i].op);
      chk($sformatf("vec%0d_SrcA", i), SrcA, tbl[i].exp_a);
      chk($sformatf("vec%0d_SrcB", i), SrcB, tbl[i].exp_b);
      chk($sformatf("vec%0d_out_rd", i), out_rd, tbl[i].rd);
      cycle();
    end

    // Back-pressure: four ops, out_ready low on cycles 2 and 3.
    begin
      int idx;
      idx = 0;
      got.delete();
      for (int k = 0; k < 9; k++) begin
        out_ready = !(k == 2 || k == 3);
        if (idx < 4) set_op(2'b00, 5'd0, 5'd0, 32'd100 + idx, 32'd0, 5'(idx + 1));
        else in_valid = 1'b0;
        if (k == 3) chk("bp_in_ready_low", in_ready, 1'b0);
        if (out_valid && out_ready) got.push_back(SrcA);
        if (in_valid && q.size() < 2) idx++;
        cycle();
      end
      chk("bp_count", got.size(), 4);
      for (int j = 0; j < 4; j++)
        if (j < got.size()) chk($sformatf("bp_order%0d", j), got[j], 32'd100 + j);
    end

    // Held entry refreshed by write-back while stalled.
    out_ready = 1'b0;
    set_op(2'b00, 5'd1, 5'd4, 32'd1, 32'd2, 5'd8);
    cycle();
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'd9;
    cycle();
    wb_valid = 1'b0;
    chk("held_refresh_SrcB", SrcB, FWD ? 32'd9 : 32'd2);
    out_ready = 1'b1;
    cycle();

    // Flush while FULL with an op offered.
    out_ready = 1'b0;
    set_op(2'b01, 5'd0, 5'd0, 32'd1, 32'd1, 5'd1);
    cycle();
    set_op(2'b01, 5'd0, 5'd0, 32'd2, 32'd2, 5'd2);
    cycle();
    chk("flush_pre_full", in_ready, 1'b0);
    flush = 1'b1; in_valid = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    cycle();

    // Random traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_op      = 2'($urandom_range(0, 3));
      in_rs_a    = 5'($urandom_range(0, 7));
      in_rs_b    = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 31));
      in_rdata_a = $urandom;
      in_rdata_b = $urandom;
      in_imm     = $urandom;
      in_use_imm = ($urandom_range(0, 3) == 0);
      wb_valid   = ($urandom_range(0, 1) == 1);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0; wb_valid = 1'b0;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    set_op(2'b11, 5'd0, 5'd0, 32'hABCD, 32'h1234, 5'd7);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_op(2'b10, 5'd0, 5'd0, 32'h77, 32'h88, 5'd3);
    cycle();
    in_valid = 1'b0;
    chk("post_rst_SrcA", SrcA, 32'h77);
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
